// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin arbiter sharing one FIFO write port
// between NUM_REQ packet requesters, with full backpressure and burst capping.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                          w_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full_flag,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
  logic [ID_W-1:0]       r_grant_id, w_grant_id_nxt;
  logic [ID_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;
  logic [ID_W-1:0]       w_winner;
  logic                  w_any_valid;
  logic                  w_sel_valid, w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_xfer, w_exit;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == r_grant_id) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Winner is the valid requester at the smallest rotational distance past rr_ptr.
  always_comb begin
    int v_best;
    int v_dist;
    v_best      = NUM_REQ;
    v_dist      = 0;
    w_winner    = '0;
    w_any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_dist = (i + NUM_REQ - 1 - int'(r_rr_ptr)) % NUM_REQ;
      if (req_valid[i] && (v_dist < v_best)) begin
        v_best      = v_dist;
        w_winner    = ID_W'(i);
        w_any_valid = 1'b1;
      end
    end
  end

  assign w_xfer = (r_state == BURST) && w_sel_valid && !full_flag;
  assign w_exit = (w_xfer && (w_sel_last || (r_beat_cnt == CNT_W'(MAX_BURST - 1))))
               || (!w_sel_valid && (r_beat_cnt == '0));

  always_comb begin
    req_ready = '0;
    if (r_state == BURST) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ID_W'(i) == r_grant_id) req_ready[i] = !full_flag;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_busy_nxt     = r_busy;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          w_state_nxt    = BURST;
          w_grant_id_nxt = w_winner;
          w_rr_ptr_nxt   = w_winner;
          w_busy_nxt     = 1'b1;
          w_beat_cnt_nxt = '0;
          for (int i = 0; i < NUM_REQ; i++) w_grant_nxt[i] = (ID_W'(i) == w_winner);
        end
      end
      BURST: begin
        if (w_exit) begin
          w_state_nxt    = IDLE;
          w_grant_nxt    = '0;
          w_busy_nxt     = 1'b0;
          w_beat_cnt_nxt = '0;
        end else if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_busy     <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_busy     <= w_busy_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  assign w_en     = w_xfer;
  assign w_data   = w_sel_data;
  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench for fifo_write_arbiter
// with per-requester packet queues driven from the handshake.
module tb_fifo_write_arbiter;

  logic        w_clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        full_flag;
  logic        w_en;
  logic [7:0]  w_data;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] q[4][$];
  logic [3:0] mask;
  logic [7:0] wlog[$];

  logic       s_w_en, s_busy;
  logic [7:0] s_w_data;
  logic [3:0] s_grant, s_ready;
  logic [1:0] s_gid;

  fifo_write_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(8)) dut (
    .w_clk(w_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .full_flag(full_flag),
    .w_en(w_en), .w_data(w_data), .grant(grant), .grant_id(grant_id), .busy(busy)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic drive_inputs();
    logic [8:0] b;
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() != 0 && !mask[i]) begin
        b = q[i][0];
        req_valid[i]         = 1'b1;
        req_data[i*8 +: 8]   = b[7:0];
        req_last[i]          = b[8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*8 +: 8]   = 8'h00;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  // Samples at the falling edge, then applies the handshake 1 ns after the rising edge.
  task automatic tick();
    logic [3:0] acc;
    @(negedge w_clk);
    s_w_en = w_en; s_w_data = w_data; s_grant = grant; s_ready = req_ready;
    s_gid = grant_id; s_busy = busy;
    if (w_en) wlog.push_back(w_data);
    acc = req_valid & req_ready;
    @(posedge w_clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) void'(q[i].pop_front());
    drive_inputs();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) q[i].delete();
    mask = 4'b0000;
    full_flag = 1'b0;
    wlog.delete();
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_all();
    repeat (2) @(posedge w_clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    q[1].push_back(9'h1_55);
    drive_inputs();
    tick();
    checks++; if (s_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b exp 0000", s_grant); end
    checks++; if (s_gid !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d exp 0", s_gid); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", s_busy); end
    checks++; if (s_w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en: got %b exp 0", s_w_en); end
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b exp 0000", s_ready); end
    do_reset();
  endtask

  task automatic test_single();
    logic [7:0] exp_d[3] = '{8'hA1, 8'hA2, 8'hA3};
    int busy_cnt = 0;
    q[0].push_back(9'h0_A1); q[0].push_back(9'h0_A2); q[0].push_back(9'h1_A3);
    drive_inputs();
    tick();
    checks++; if (s_grant !== 4'b0000 || s_w_en !== 1'b0) begin errors++; $display("FAIL single_idle: grant %b w_en %b exp 0000 0", s_grant, s_w_en); end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (s_busy) busy_cnt++;
      checks++;
      if (s_grant !== 4'b0001 || s_w_en !== 1'b1 || s_w_data !== exp_d[c]) begin
        errors++; $display("FAIL single_beat%0d: grant %b w_en %b data %h exp 0001 1 %h", c, s_grant, s_w_en, s_w_data, exp_d[c]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (s_busy) busy_cnt++;
    end
    checks++; if (s_grant !== 4'b0000 || s_w_en !== 1'b0) begin errors++; $display("FAIL single_end: grant %b w_en %b exp 0000 0", s_grant, s_w_en); end
    checks++; if (busy_cnt != 3) begin errors++; $display("FAIL single_busy_cycles: got %0d exp 3", busy_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g[13] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0};
    logic [7:0] exp_w[6] = '{8'h01, 8'h11, 8'h31, 8'h02, 8'h12, 8'h32};
    do_reset();
    q[0].push_back(9'h1_01); q[0].push_back(9'h1_02);
    q[1].push_back(9'h1_11); q[1].push_back(9'h1_12);
    q[3].push_back(9'h1_31); q[3].push_back(9'h1_32);
    drive_inputs();
    for (int c = 0; c < 13; c++) begin
      tick();
      checks++;
      if (s_grant !== exp_g[c]) begin errors++; $display("FAIL rr_grant c%0d: got %b exp %b", c, s_grant, exp_g[c]); end
    end
    checks++;
    if (wlog.size() != 6) begin errors++; $display("FAIL rr_count: got %0d exp 6", wlog.size()); end
    else for (int k = 0; k < 6; k++) if (wlog[k] !== exp_w[k]) begin errors++; $display("FAIL rr_data%0d: got %h exp %h", k, wlog[k], exp_w[k]); end
  endtask

  task automatic test_max_burst();
    logic [7:0] exp_w[14] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47,
                              8'h50, 8'h51, 8'h48, 8'h49, 8'h4A, 8'h4B};
    do_reset();
    for (int k = 0; k < 12; k++) q[1].push_back({(k == 11), 8'(8'h40 + k)});
    q[2].push_back(9'h0_50); q[2].push_back(9'h1_51);
    drive_inputs();
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 9) begin
        checks++; if (s_w_en !== 1'b0 || s_grant !== 4'b0000) begin errors++; $display("FAIL burst_cap_idle: w_en %b grant %b exp 0 0000", s_w_en, s_grant); end
      end
    end
    checks++;
    if (wlog.size() != 14) begin errors++; $display("FAIL burst_count: got %0d exp 14", wlog.size()); end
    else for (int k = 0; k < 14; k++) if (wlog[k] !== exp_w[k]) begin errors++; $display("FAIL burst_data%0d: got %h exp %h", k, wlog[k], exp_w[k]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 10; k++) q[0].push_back({(k == 9), 8'(8'h60 + k)});
    drive_inputs();
    repeat (3) tick();
    full_flag = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (s_w_en !== 1'b0 || s_ready !== 4'b0000 || s_grant !== 4'b0001 || s_busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold c%0d: w_en %b ready %b grant %b busy %b exp 0 0000 0001 1", c, s_w_en, s_ready, s_grant, s_busy);
      end
    end
    full_flag = 1'b0;
    tick();
    checks++; if (s_w_en !== 1'b1 || s_w_data !== 8'h62) begin errors++; $display("FAIL bp_resume: w_en %b data %h exp 1 62", s_w_en, s_w_data); end
    repeat (5) tick();
    tick();
    checks++; if (s_busy !== 1'b0 || s_w_en !== 1'b0) begin errors++; $display("FAIL bp_cap_after_hold: busy %b w_en %b exp 0 0", s_busy, s_w_en); end
    repeat (4) tick();
    checks++;
    if (wlog.size() != 10) begin errors++; $display("FAIL bp_count: got %0d exp 10", wlog.size()); end
    else for (int k = 0; k < 10; k++) if (wlog[k] !== 8'(8'h60 + k)) begin errors++; $display("FAIL bp_data%0d: got %h exp %h", k, wlog[k], 8'(8'h60 + k)); end
  endtask

  task automatic test_withdraw();
    clear_all();
    q[3].push_back(9'h1_3F);
    drive_inputs();
    tick();
    mask[3] = 1'b1;
    q[0].push_back(9'h1_77);
    drive_inputs();
    tick();
    checks++; if (s_grant !== 4'b1000 || s_busy !== 1'b1 || s_w_en !== 1'b0) begin errors++; $display("FAIL wd_burst: grant %b busy %b w_en %b exp 1000 1 0", s_grant, s_busy, s_w_en); end
    tick();
    checks++; if (s_grant !== 4'b0000 || s_busy !== 1'b0) begin errors++; $display("FAIL wd_idle: grant %b busy %b exp 0000 0", s_grant, s_busy); end
    tick();
    checks++; if (s_grant !== 4'b0001 || s_w_en !== 1'b1 || s_w_data !== 8'h77) begin errors++; $display("FAIL wd_next: grant %b w_en %b data %h exp 0001 1 77", s_grant, s_w_en, s_w_data); end
    tick();
    checks++; if (wlog.size() != 1) begin errors++; $display("FAIL wd_count: got %0d exp 1", wlog.size()); end
    q[3].delete(); mask = 4'b0000;
    drive_inputs();
  endtask

  task automatic test_reset_mid();
    clear_all();
    for (int k = 0; k < 6; k++) q[2].push_back({(k == 5), 8'(8'h80 + k)});
    drive_inputs();
    repeat (4) tick();
    #2;
    checks++; if (w_en !== 1'b1 || w_data !== 8'h83 || grant_id !== 2'd2) begin errors++; $display("FAIL rm_before: w_en %b data %h gid %0d exp 1 83 2", w_en, w_data, grant_id); end
    rst = 1'b0;
    #1;
    checks++;
    if (w_en !== 1'b0 || grant !== 4'b0000 || grant_id !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL rm_async: w_en %b grant %b gid %0d busy %b ready %b exp 0 0000 0 0 0000", w_en, grant, grant_id, busy, req_ready);
    end
    q[2].delete();
    q[0].push_back(9'h1_90);
    q[2].push_back(9'h1_A0);
    drive_inputs();
    tick();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (s_grant !== 4'b0001 || s_w_data !== 8'h90) begin errors++; $display("FAIL rm_first: grant %b data %h exp 0001 90", s_grant, s_w_data); end
    tick();
    tick();
    checks++; if (s_grant !== 4'b0100 || s_w_data !== 8'hA0) begin errors++; $display("FAIL rm_second: grant %b data %h exp 0100 a0", s_grant, s_w_data); end
  endtask

  initial begin
    rst = 1'b0;
    clear_all();
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst();
    test_backpressure();
    test_withdraw();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of the asynchronous FIFO between NUM_REQ requesters in the write-clock domain. Each requester presents packets through a valid/ready handshake with a last marker. The arbiter grants one requester at a time and forwards its beats to the FIFO write port. It holds off all writes while full_flag is high and caps each grant at MAX_BURST beats so that no requester can starve the others.

Parameters:
DATA_WIDTH, 8, width of one data beat
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 8, maximum beats per grant before forced re-arbitration (>=1)

Ports:
w_clk  input  1  write-domain clock, rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester beat valid
req_data  input  NUM_REQ*DATA_WIDTH  per-requester beat, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  per-requester last beat of packet
req_ready  output  NUM_REQ  per-requester beat accepted this cycle
full_flag  input  1  FIFO full, write-domain synchronous
w_en  output  1  FIFO write strobe
w_data  output  DATA_WIDTH  FIFO write data
grant  output  NUM_REQ  one-hot current grant, registered
grant_id  output  clog2(NUM_REQ)  binary index of the granted requester, registered
busy  output  1  high while in BURST

Behaviour:
- Reset (rst low, async): state=IDLE, grant=0, grant_id=0, busy=0, beat_cnt=0, rr_ptr=NUM_REQ-1 (requester 0 has top priority first). w_en=0 and req_ready=0 while rst is low.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid is high, pick the first requester with valid high, searching from rr_ptr+1 upward, modulo NUM_REQ.
  - Registered at the next edge: grant and grant_id set, rr_ptr set to the winner, beat_cnt=0, state=BURST.
  - No transfers occur in IDLE. If no request is pending, remain in IDLE.
- BURST:
  - xfer = req_valid[g] & !full_flag, where g = grant_id.
  - req_ready[g] = !full_flag, combinational. All other req_ready bits are 0.
  - w_en = xfer, combinational, zero latency. w_data = req_data slice g, passed through combinationally.
  - Every cycle with xfer: beat_cnt increments.
- Leaving BURST (registered at the edge of the cycle in which the condition holds): state=IDLE, grant=0, busy=0, beat_cnt=0. rr_ptr is retained. Exit conditions:
  - xfer with req_last[g]=1 (end of packet);
  - xfer with beat_cnt==MAX_BURST-1 (forced re-arbitration);
  - req_valid[g]=0 while beat_cnt==0 (request withdrawn before its first beat).
- Burst truncated by MAX_BURST: the requester keeps its remaining beats pending. It competes again with the lowest priority, since rr_ptr now points to it.
- req_valid[g] low mid-packet (beat_cnt>0): hold the grant and wait. There is no timeout.
- full_flag high: req_ready=0, w_en=0, beat_cnt holds, grant holds. Transfers resume the first cycle full_flag is low.
- Last beat coinciding with the MAX_BURST limit: a single exit, with identical result.
- Arbitration overhead: exactly one IDLE cycle between consecutive grants. Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Requester protocol: req_data and req_last must stay stable while req_valid is high and not yet accepted.
- busy equals (state==BURST) and is registered.
- Async reset mid-BURST: everything returns to reset values immediately and w_en drops combinationally. A partially sent packet is not resumed by the arbiter.
- beat_cnt width: clog2(MAX_BURST)+1. No wrap is possible, because exit is forced at MAX_BURST-1.

Test Plan:
- Reset then single requester: req 0 sends a 3-beat packet 0xA1,0xA2,0xA3 (last on beat 3), full_flag=0 -> grant=0001 one cycle after valid; w_en high 3 consecutive cycles with those values; IDLE on the next edge; busy high for exactly 3 cycles.
- Round robin: reqs 0,1,3 each hold a 1-beat packet from reset -> grant order 0,1,3,0,... with exactly one IDLE cycle between grants; req 2 never granted.
- MAX_BURST=8, req 1 sends a 12-beat packet while req 2 has a 2-beat packet pending -> 8 beats from req 1, then req 2's 2 beats, then req 1's remaining 4 beats; total 14 writes and no lost or duplicated data.
- Backpressure: full_flag high for 5 cycles mid-burst on beat 2 -> w_en=0 and req_ready=0 for those 5 cycles; beat_cnt stays at 2; the burst completes after full_flag drops.
- Withdrawn request: req 3 valid for 1 cycle, granted, then valid=0 with beat_cnt=0 -> returns to IDLE after 1 BURST cycle with no write. Then req 0 pending -> granted next.
- Reset mid-burst on beat 4 of 6 -> w_en drops immediately and all outputs take reset values. After rst deasserts with req 0 and req 2 pending -> req 0 is granted first.
